// File: rtl/iseq_host_driver.sv
// rtl/iseq_host_driver.sv - host-side driver that stages, issues and drains a softMC instruction sequence
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   stage_wr/stage_instr          host pushes instructions into the staging buffer (IDLE only)
//   stage_full/stage_count        staging buffer occupancy
//   start/rd_expected             launch pulse and number of read-back words to drain
//   busy/done/timeout_err         status: busy outside IDLE, one-cycle done, sticky timeout
//   app_en/app_instr/app_ack      softMC instruction handshake, iq_full back-pressure
//   processing_iseq               softMC executing flag
//   rdback_fifo_*/rdback_data     softMC read-back FIFO (dout valid one cycle after rden)
//   rd_valid/rd_ready/rd_data     host read-back stream, rd_count words delivered
module iseq_host_driver #(
  parameter int DQ_WIDTH     = 64,
  parameter int STAGE_DEPTH  = 16,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stage_wr,
  input  logic [31:0]                    stage_instr,
  output logic                           stage_full,
  output logic [$clog2(STAGE_DEPTH):0]   stage_count,
  input  logic                           start,
  input  logic [15:0]                    rd_expected,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout_err,
  output logic                           app_en,
  output logic [31:0]                    app_instr,
  input  logic                           app_ack,
  input  logic                           iq_full,
  input  logic                           processing_iseq,
  input  logic                           rdback_fifo_empty,
  output logic                           rdback_fifo_rden,
  input  logic [4*DQ_WIDTH-1:0]          rdback_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [4*DQ_WIDTH-1:0]          rd_data,
  output logic [15:0]                    rd_count
);

  localparam int AW = $clog2(STAGE_DEPTH);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEND, S_GAP, S_WAIT_BUSY, S_WAIT_IDLE,
    S_DRAIN_REQ, S_DRAIN_CAP, S_DRAIN_OUT, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   mem [STAGE_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   rd_exp_q;
  logic [CW-1:0] to_cnt;
  logic          push, pop, accept_start, set_timeout, rd_fire;

  assign stage_count = count;
  assign stage_full  = (count == (AW+1)'(STAGE_DEPTH));

  always_comb begin
    state_nx         = state;
    app_en           = 1'b0;
    app_instr        = '0;
    rdback_fifo_rden = 1'b0;
    rd_valid         = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    accept_start     = 1'b0;
    set_timeout      = 1'b0;
    rd_fire          = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        push = stage_wr && !stage_full;
        if (start) begin
          accept_start = 1'b1;
          state_nx     = (count != '0) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        // head stays on app_instr while iq_full back-pressures, so nothing is lost
        app_instr = mem[rd_ptr];
        app_en    = !iq_full;
        if (!iq_full && app_ack) begin
          pop      = 1'b1;
          state_nx = S_GAP;
        end
      end
      S_GAP:       state_nx = (count != '0) ? S_SEND : S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (processing_iseq) begin
          state_nx = S_WAIT_IDLE;
        end else if (to_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // softMC never reported busy; flag it and fall through to the drain path
          set_timeout = 1'b1;
          state_nx    = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (!processing_iseq) state_nx = (rd_exp_q != '0) ? S_DRAIN_REQ : S_DONE;
      end
      S_DRAIN_REQ: begin
        if (!rdback_fifo_empty) begin
          rdback_fifo_rden = 1'b1;
          state_nx         = S_DRAIN_CAP;
        end
      end
      S_DRAIN_CAP: state_nx = S_DRAIN_OUT;
      S_DRAIN_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          rd_fire  = 1'b1;
          state_nx = (rd_count + 16'd1 == rd_exp_q) ? S_DONE : S_DRAIN_REQ;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_exp_q    <= '0;
      rd_count    <= '0;
      rd_data     <= '0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
    end else begin
      state <= state_nx;
      // push happens only in IDLE and pop only in SEND, so they never collide
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
      if (accept_start) begin
        rd_exp_q    <= rd_expected;
        rd_count    <= '0;
        timeout_err <= 1'b0;
      end
      if (set_timeout) timeout_err <= 1'b1;
      to_cnt <= (state == S_WAIT_BUSY) ? to_cnt + 1'b1 : '0;
      if (state == S_DRAIN_CAP) rd_data <= rdback_data;
      if (rd_fire) rd_count <= rd_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stage_instr;
  end

endmodule

// File: tb/tb_iseq_host_driver.sv
// tb/tb_iseq_host_driver.sv - self-checking bench for iseq_host_driver against a queue-based softMC/host model
module tb_iseq_host_driver;
  localparam int DQ = 64;
  localparam int DW = 4 * DQ;
  localparam int SD = 16;
  localparam int BT = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          stage_wr;
  logic [31:0]   stage_instr;
  logic          stage_full;
  logic [4:0]    stage_count;
  logic          start;
  logic [15:0]   rd_expected;
  logic          busy, done, timeout_err;
  logic          app_en;
  logic [31:0]   app_instr;
  logic          app_ack, iq_full, processing_iseq;
  logic          rdback_fifo_empty, rdback_fifo_rden;
  logic [DW-1:0] rdback_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic [15:0]   rd_count;

  always #5 clk = ~clk;

  iseq_host_driver #(.DQ_WIDTH(DQ), .STAGE_DEPTH(SD), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst),
    .stage_wr(stage_wr), .stage_instr(stage_instr), .stage_full(stage_full), .stage_count(stage_count),
    .start(start), .rd_expected(rd_expected), .busy(busy), .done(done), .timeout_err(timeout_err),
    .app_en(app_en), .app_instr(app_instr), .app_ack(app_ack), .iq_full(iq_full),
    .processing_iseq(processing_iseq),
    .rdback_fifo_empty(rdback_fifo_empty), .rdback_fifo_rden(rdback_fifo_rden), .rdback_data(rdback_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_count(rd_count)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0]   stage_q[$];
  logic [DW-1:0] rb_q[$];
  logic [DW-1:0] out_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_inputs();
    stage_wr = 0; stage_instr = '0; start = 0; rd_expected = '0;
    app_ack = 0; iq_full = 0; processing_iseq = 0;
    rdback_fifo_empty = 1; rdback_data = '0; rd_ready = 0;
  endtask

  task automatic stage(input logic [31:0] ins);
    @(negedge clk);
    stage_wr = 1; stage_instr = ins;
    if (stage_q.size() < SD) stage_q.push_back(ins);
    @(negedge clk);
    stage_wr = 0;
    #1;
    chk("stage_count", stage_count, stage_q.size());
    chk("stage_full", stage_full, stage_q.size() == SD);
  endtask

  // One complete launch: the bench plays softMC and the host reader around the DUT.
  task automatic run_op(input int rd_exp, input int iq_pct, input int rdy_pct, input int iq_hold,
                        input int rdy_hold, input bit never_busy, input bit abort_drain);
    int n = stage_q.size();
    int exp_rd = (n > 0) ? rd_exp : 0;
    int sent = 0, cyc = 0, post = 0, ack_wait = 0, hold_cnt = 0, vcnt = 0;
    int rden_cnt = 0, got = 0, last_ack = 0, to_cyc = -1, last_rden = -10;
    bit exp_gap = 0, fin = 0, aborted = 0;
    logic [DW-1:0] dout = '0;
    rb_q.delete(); out_q.delete();
    for (int i = 0; i < exp_rd; i++) begin
      logic [DW-1:0] w;
      w = rand_word();
      rb_q.push_back(w); out_q.push_back(w);
    end
    @(negedge clk);
    start = 1; rd_expected = 16'(rd_exp);
    #1;
    chk("busy_idle", busy, 0);
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = ($urandom_range(7) == 0); rd_expected = 16'($urandom);
      stage_wr = ($urandom_range(7) == 0); stage_instr = $urandom;
      rdback_data = dout;
      rdback_fifo_empty = (rb_q.size() == 0);
      if (sent == 1 && hold_cnt < iq_hold) begin
        iq_full = 1; hold_cnt++;
      end else begin
        iq_full = (sent < n) && ($urandom_range(99) < iq_pct);
      end
      processing_iseq = !never_busy && sent == n && post >= 3 && post < 8;
      if (sent == n) post++;
      rd_ready = (got > 0 || vcnt >= rdy_hold) && ($urandom_range(99) < rdy_pct);
      #1;
      if (exp_gap) begin
        chk("app_en_gap", app_en, 0);
        exp_gap = 0;
      end
      if (iq_full) chk("app_en_iq_full", app_en, 0);
      if (app_en) begin
        if (stage_q.size() == 0) begin
          chk("app_en_extra", app_en, 0);
          app_ack = 0;
        end else begin
          chk("app_instr", app_instr, stage_q[0]);
          if (ack_wait == 0) begin
            app_ack = 1; void'(stage_q.pop_front()); sent++;
            exp_gap = 1; last_ack = cyc; ack_wait = $urandom_range(2);
          end else begin
            app_ack = 0; ack_wait--;
          end
        end
      end else begin
        app_ack = ($urandom_range(3) == 0);
      end
      if (rdback_fifo_rden) begin
        chk("rden_nonempty", rdback_fifo_empty, 0);
        if (rden_cnt > 0) chk("rden_spacing", (cyc - last_rden) >= 3, 1);
        rden_cnt++; last_rden = cyc;
        if (rb_q.size() > 0) dout = rb_q.pop_front();
      end
      if (rd_valid) begin
        if (abort_drain) begin
          aborted = 1; fin = 1;
        end else if (out_q.size() == 0) begin
          chk("rd_valid_extra", rd_valid, 0);
        end else begin
          chk("rd_data", rd_data, out_q[0]);
          vcnt++;
          if (rd_ready) begin
            void'(out_q.pop_front()); got++; vcnt = 0;
          end
        end
      end
      if (timeout_err && to_cyc < 0) to_cyc = cyc;
      if (done) begin
        chk("done_busy", busy, 1);
        fin = 1;
      end
    end
    chk("op_cycle_budget", fin, 1);
    if (aborted) begin
      rst = 1;
      @(negedge clk);
      #1;
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_count", rd_count, 0);
      chk("rst_stage_count", stage_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_app_en", app_en, 0);
      chk("rst_rden", rdback_fifo_rden, 0);
      chk("rst_rd_data", rd_data, 0);
      rst = 0; idle_inputs(); stage_q.delete();
    end else begin
      chk("rd_count", rd_count, exp_rd);
      chk("rden_count", rden_cnt, exp_rd);
      chk("timeout_err", timeout_err, never_busy && n > 0);
      chk("all_sent", sent, n);
      if (never_busy && n > 0) chk("timeout_latency", to_cyc - last_ack, BT + 2);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("done_one_cycle", done, 0);
      chk("busy_after", busy, 0);
      chk("stage_count_after", stage_count, 0);
      chk("rd_count_hold", rd_count, exp_rd);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_stage_count", stage_count, 0);
    chk("reset_stage_full", stage_full, 0);
    chk("reset_app_en", app_en, 0);
    chk("reset_app_instr", app_instr, 0);
    chk("reset_rden", rdback_fifo_rden, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_count", rd_count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_timeout_err", timeout_err, 0);

    // three instructions, no read-back
    stage(32'h11); stage(32'h22); stage(32'h33);
    run_op(0, 0, 100, 0, 0, 0, 0);

    // iq_full held for 10 cycles after the first instruction
    stage(32'h11); stage(32'h22); stage(32'h33);
    run_op(0, 0, 100, 10, 0, 0, 0);

    // overfill: 17th write dropped
    for (int i = 0; i < 17; i++) stage(32'h100 + i);
    run_op(0, 20, 100, 0, 0, 0, 0);

    // two read-back words, reader stalls on the first
    stage(32'hA1); stage(32'hA2);
    run_op(2, 0, 100, 0, 5, 0, 0);

    // processing_iseq never rises
    stage(32'hB1);
    run_op(1, 0, 100, 0, 0, 1, 0);

    // start with an empty buffer
    run_op(3, 0, 100, 0, 0, 0, 0);

    // randomized launches
    for (int t = 0; t < 6; t++) begin
      int ni;
      ni = $urandom_range(1, 6);
      for (int i = 0; i < ni; i++) stage($urandom);
      run_op($urandom_range(0, 3), 30, 60, 0, $urandom_range(0, 3), 0, 0);
    end

    // reset while a read-back word is presented, then recover
    stage(32'hC1); stage(32'hC2);
    run_op(1, 0, 0, 0, 0, 0, 1);
    stage(32'hD1);
    run_op(1, 10, 70, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
